burst_memory: RTL and testbench
===============================

// Module: burst_memory
// PURPOSE
//  Parametrised synchronous main memory for the MIPS core and its loaders/benches.
//  Byte-addressed, word-organised, based at START_ADDR. Supports single-word and
//  incrementing bursts of 4/8/16 words, with a busy/data_valid handshake.
//  Sits between fetch/load-store logic (or a program loader) and the storage array.
// PARAMETERS
//  DATA_WIDTH   32            word width in bits (multiple of 8)
//  ADDR_WIDTH   32            byte address width
//  DEPTH_WORDS  262144        words of storage (power of 2; 1 MiB at 32 bits)
//  START_ADDR   32'h80020000  byte address of word index 0
// PORTS
//  clock        in   1           sole clock, rising edge
//  reset_n      in   1           asynchronous, active-low reset
//  address      in   ADDR_WIDTH  byte address of first beat; sampled on accept only
//  data_in      in   DATA_WIDTH  write data, one word per beat
//  access_size  in   2           00=1 word, 01=4, 10=8, 11=16 beats
//  rw           in   1           0=write, 1=read; sampled on accept
//  enable       in   1           command request
//  busy         out  1           1 = burst in progress, new commands ignored
//  data_out     out  DATA_WIDTH  read data, registered
//  data_valid   out  1           data_out holds a read beat this cycle
//  err          out  1           one-cycle error pulse (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): busy=0, data_valid=0, data_out=0, err=0,
//    FSM=IDLE, beat counter=0. Array contents NOT cleared. Reset mid-burst aborts it;
//    beats already written stay written.
//  - Accept: rising edge with enable=1 and busy=0. Index = (address-START_ADDR)>>2,
//    modulo DEPTH_WORDS. Beat k uses index+k modulo DEPTH_WORDS (wraps to word 0).
//  - FSM: IDLE -> (accept, N>1) BURST_WR or BURST_RD -> IDLE after beat N-1.
//    N=1 stays in IDLE; back-to-back single-word commands accepted every cycle.
//  - busy: 1 for cycles 1..N-1 after the accept edge (cycle 0); 0 for N=1.
//    Command inputs (enable, address, rw, access_size) ignored while busy=1.
//  - Write: beat 0 data_in captured at accept edge; beat k captured at edge k.
//    Source must present the next word every cycle; no stalls within a burst.
//  - Read: beat k on data_out with data_valid=1 in cycle k+1 (1-cycle latency),
//    N consecutive valid cycles. data_out holds last value when data_valid=0.
//  - Read-after-write: a read accepted the cycle after a write to the same word
//    returns the new data (write completes at its edge).
//  - Low two address bits ignored (word aligned) unless MEM_ADDR_CHECK_EN.
// CONFIGURATION
//  MEM_ADDR_CHECK_EN defined: at accept, if address < START_ADDR, address >=
//    START_ADDR+4*DEPTH_WORDS, address[1:0]!=0, or the burst would cross the top
//    word, command is dropped: no write, no data_valid, busy stays 0, err=1 for the
//    cycle after accept. Valid commands never raise err.
//  Not defined: no checking, err tied 0, out-of-range indices wrap modulo DEPTH_WORDS.
// TESTING
//  1. reset_n=0 during a 16-beat read -> busy,data_valid,err=0 asynchronously; array intact.
//  2. Write 0xDEADBEEF @80020000 size 00, read same next cycle -> data_valid
//     one cycle later, data_out=DEADBEEF; busy never 1.
//  3. 4-beat write 11,22,33,44 @80020010, 4-beat read -> busy 3 cycles; data_valid
//     4 consecutive cycles returning 11,22,33,44.
//  4. enable=1 write @80020000 data 0xFF while 8-beat read busy -> ignored; read data
//     and memory unchanged.
//  5. 4-beat read starting at last word minus 1 (no macro) -> beats 2,3 wrap to
//     words 0,1 of the array.
//  6. MEM_ADDR_CHECK_EN: read @80020002, then write @7FFFFFFC -> err pulse each,
//     no data_valid, target memory unchanged; subsequent valid read err=0.

Source files
------------

// File: rtl/burst_memory_if.sv
// Command/response bus for burst_memory: command request, write data, and the
// busy/data_valid/err response lines.
interface burst_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            access_size;
  logic                  rw;
  logic                  enable;
  logic                  busy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  err;

  modport master (
    output address, data_in, access_size, rw, enable,
    input  busy, data_out, data_valid, err
  );

  modport slave (
    input  address, data_in, access_size, rw, enable,
    output busy, data_out, data_valid, err
  );
endinterface

// File: rtl/burst_memory.sv
// Word-organised synchronous main memory with 1/4/8/16-beat incrementing bursts.
// Optional MEM_ADDR_CHECK_EN drops out-of-range/misaligned/top-crossing commands and pulses err.
module burst_memory #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 262144,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 32'h80020000
) (
  input  logic           clock,
  input  logic           reset_n,
  burst_memory_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BURST_WR,
    BURST_RD
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            beat_q, beat_d;
  logic [3:0]            last_q, last_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;

  logic                  accept;
  logic                  cmd_ok;
  logic [3:0]            cmd_last;
  logic [IDX_W-1:0]      start_idx;

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  assign accept    = bus.enable && (state_q == IDLE);
  assign start_idx = IDX_W'((bus.address - START_ADDR) >> 2);

  always_comb begin
    case (bus.access_size)
      2'b00:   cmd_last = 4'd0;
      2'b01:   cmd_last = 4'd3;
      2'b10:   cmd_last = 4'd7;
      default: cmd_last = 4'd15;
    endcase
  end

`ifdef MEM_ADDR_CHECK_EN
  // Limit is computed one bit wider so a region ending at the top of the address space cannot overflow.
  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, START_ADDR} + ((ADDR_WIDTH+1)'(DEPTH_WORDS) << 2);

  logic [IDX_W:0] end_idx;
  logic           err_q, err_d;

  always_comb begin
    end_idx = {1'b0, start_idx} + (IDX_W+1)'(cmd_last);
    cmd_ok  = (bus.address >= START_ADDR) &&
              ({1'b0, bus.address} < END_ADDR) &&
              (bus.address[1:0] == 2'b00) &&
              !end_idx[IDX_W];
  end

  assign err_d   = accept && !cmd_ok;
  assign bus.err = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`else
  assign cmd_ok  = 1'b1;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      last_q       <= '0;
      idx_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_q       <= last_d;
      idx_q        <= idx_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Beat 0 is handled at the accept edge, so a burst enters its state already on beat 1.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept && cmd_ok && (cmd_last != 4'd0)) begin
          state_d = bus.rw ? BURST_RD : BURST_WR;
          beat_d  = 4'd1;
          last_d  = cmd_last;
          idx_d   = start_idx + 1'b1;
        end
      end
      BURST_WR, BURST_RD: begin
        idx_d  = idx_q + 1'b1;
        beat_d = beat_q + 4'd1;
        if (beat_q == last_q) begin
          state_d = IDLE;
          beat_d  = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we       = 1'b0;
    mem_idx      = idx_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && cmd_ok) begin
          mem_idx = start_idx;
          if (bus.rw) begin
            data_out_d   = rd_word;
            data_valid_d = 1'b1;
          end else begin
            mem_we = 1'b1;
          end
        end
      end
      BURST_WR: mem_we = 1'b1;
      BURST_RD: begin
        data_out_d   = rd_word;
        data_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign rd_word = mem[mem_idx];

  // Storage is deliberately not reset: contents survive reset and aborted bursts.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_idx] <= bus.data_in;
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

endmodule

// File: tb/tb_burst_memory.sv
// Scoreboard bench for burst_memory: reads push expected words, a negedge monitor pops them.
// Handshake timing, wrap-around, command-ignore-while-busy and async reset are checked inline.
module tb_burst_memory;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] START = 32'h80020000;

  logic clock;
  logic reset_n;

  burst_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  burst_memory #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(DEPTH),
    .START_ADDR (START)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [int];
  logic [31:0] wdata [16];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("unexpected_valid", 32'd1, 32'd0);
      else                   checkOutput("rd_data", bus.data_out, exp_q.pop_front());
    end
  end

  // Issues one command starting at a negedge and returns at the negedge of cycle N.
  task automatic applyStimulus(input logic is_read, input logic [31:0] addr,
                               input logic [1:0] size, input logic poke);
    int      n;
    int      idx;
    logic    ok;
    longint  a;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 4 : (size == 2'd2) ? 8 : 16;
    idx = int'(((addr - START) >> 2) % DEPTH);
    a   = longint'(addr);
    ok  = 1'b1;
`ifdef MEM_ADDR_CHECK_EN
    ok = (a >= longint'(START)) && (a < longint'(START) + 4 * DEPTH) &&
         (addr[1:0] == 2'b00) && (idx + n <= DEPTH);
`endif
    bus.enable      = 1'b1;
    bus.rw          = is_read;
    bus.address     = addr;
    bus.access_size = size;
    bus.data_in     = wdata[0];
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        if (is_read) exp_q.push_back(model_mem[(idx + k) % DEPTH]);
        else         model_mem[(idx + k) % DEPTH] = wdata[k];
      end
    end
    @(posedge clock);
    if (ok) begin
      for (int k = 1; k < n; k++) begin
        @(negedge clock);
        checkOutput("busy_burst", {31'd0, bus.busy}, 32'd1);
        checkOutput("valid_burst", {31'd0, bus.data_valid}, {31'd0, is_read});
        if (poke) begin
          bus.enable  = 1'b1;
          bus.rw      = 1'b0;
          bus.address = START;
          bus.data_in = 32'h000000FF;
        end else begin
          bus.enable  = 1'b0;
          bus.data_in = wdata[k];
        end
        @(posedge clock);
      end
    end
    @(negedge clock);
    bus.enable = 1'b0;
    checkOutput("busy_end", {31'd0, bus.busy}, 32'd0);
    checkOutput("valid_end", {31'd0, bus.data_valid}, {31'd0, ok & is_read});
    checkOutput("err", {31'd0, bus.err}, {31'd0, ~ok});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n         = 1'b0;
    bus.enable      = 1'b0;
    bus.rw          = 1'b0;
    bus.address     = START;
    bus.access_size = 2'b00;
    bus.data_in     = '0;
    for (int i = 0; i < 16; i++) wdata[i] = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
    checkOutput("rst_data_out", bus.data_out, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    $display("[TB] single-word write then read next cycle");
    wdata[0] = 32'hDEADBEEF;
    applyStimulus(1'b0, START, 2'b00, 1'b0);
    applyStimulus(1'b1, START, 2'b00, 1'b0);

    $display("[TB] 4-beat write and read back");
    wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
    applyStimulus(1'b0, START + 32'h10, 2'b01, 1'b0);
    applyStimulus(1'b1, START + 32'h10, 2'b01, 1'b0);

    $display("[TB] commands ignored during an 8-beat read");
    for (int i = 0; i < 8; i++) wdata[i] = 32'hA0000000 + 32'(i * 7);
    applyStimulus(1'b0, START, 2'b10, 1'b0);
    applyStimulus(1'b1, START, 2'b10, 1'b1);
    applyStimulus(1'b1, START, 2'b00, 1'b0);

    $display("[TB] burst wrapping past the top word");
    wdata[0] = 32'hCAFE0001;
    applyStimulus(1'b0, START + 32'(4 * (DEPTH - 2)), 2'b00, 1'b0);
    wdata[0] = 32'hCAFE0002;
    applyStimulus(1'b0, START + 32'(4 * (DEPTH - 1)), 2'b00, 1'b0);
    applyStimulus(1'b1, START + 32'(4 * (DEPTH - 2)), 2'b01, 1'b0);

    $display("[TB] misaligned and below-base commands");
    applyStimulus(1'b1, START + 32'h2, 2'b00, 1'b0);
    wdata[0] = 32'h5A5A5A5A;
    applyStimulus(1'b0, 32'h7FFFFFFC, 2'b00, 1'b0);
    applyStimulus(1'b1, START + 32'(4 * (DEPTH - 1)), 2'b00, 1'b0);
    applyStimulus(1'b1, START, 2'b00, 1'b0);

    $display("[TB] reset during a 16-beat read");
    for (int i = 0; i < 16; i++) wdata[i] = 32'h0BEE0000 + 32'(i);
    applyStimulus(1'b0, START, 2'b11, 1'b0);
    bus.enable      = 1'b1;
    bus.rw          = 1'b1;
    bus.address     = START;
    bus.access_size = 2'b11;
    for (int k = 0; k < 16; k++) exp_q.push_back(model_mem[k]);
    @(posedge clock);
    #1 bus.enable = 1'b0;
    repeat (5) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("async_valid", {31'd0, bus.data_valid}, 32'd0);
    checkOutput("async_err", {31'd0, bus.err}, 32'd0);
    checkOutput("async_data_out", bus.data_out, 32'd0);
    exp_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    applyStimulus(1'b1, START, 2'b11, 1'b0);

    repeat (2) @(negedge clock);
    checkOutput("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
